// File: rtl/clock_gen_rst_seq_pkg.sv
// Shared types and helpers for the clock generator reset sequencer.
package clock_gen_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    // Bits needed for a counter that runs 0..n-1 (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clock_gen_rst_seq_if.sv
// PLL-lock / reset-channel bundle between the sequencer and its environment.
interface clock_gen_rst_seq_if #(
    parameter int NUM_RST = 2,
    parameter int CNT_W   = 8
);
    logic               i_locked;
    logic [NUM_RST-1:0] o_rst;
    logic               o_ready;
    logic [CNT_W-1:0]   o_loss_cnt;
    logic               o_pll_areset;

    modport master (output i_locked, input o_rst, input o_ready, input o_loss_cnt, input o_pll_areset);
    modport slave  (input i_locked, output o_rst, output o_ready, output o_loss_cnt, output o_pll_areset);
endinterface

// File: rtl/clock_gen_rst_seq_sync.sv
// Generic two-flop synchroniser with synchronous active-high reset.
module cdc_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/clock_gen_rst_seq.sv
// Reset sequencer: qualifies PLL lock, releases NUM_RST reset channels in
// staggered order, and re-asserts all of them on a filtered lock loss.
// Optional macro PLL_WATCHDOG_EN adds a PLL re-reset watchdog in WAIT_LOCK.
//
//   state     | meaning
//   WAIT_LOCK | all resets held, waiting for synchronised lock
//   HOLD      | lock seen, counting continuous lock cycles
//   RELEASE   | o_rst[0] released, remaining channels released every STAGGER
//   RUN       | all channels released, o_ready high
module clock_gen_rst_seq
    import clock_gen_pkg::*;
#(
    parameter int NUM_RST     = 2,
    parameter int HOLD_CYCLES = 512,
    parameter int STAGGER     = 16,
    parameter int LOSS_FILT   = 4,
    parameter int CNT_W       = 8,
    parameter int WD_CYCLES   = 65536,
    parameter int AR_CYCLES   = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    clock_gen_rst_seq_if.slave  bus
);
    localparam int HW = cnt_w(HOLD_CYCLES);
    localparam int SW = cnt_w(STAGGER);
    localparam int FW = cnt_w(LOSS_FILT);
    localparam int RW = cnt_w(NUM_RST);

    // hold_cnt reaches HOLD_CYCLES-1 on the release edge, so compare one below.
    localparam logic [HW-1:0]    HOLD_LAST = HW'((HOLD_CYCLES >= 2) ? HOLD_CYCLES - 2 : 0);
    localparam logic [SW-1:0]    STG_LAST  = SW'(STAGGER - 1);
    localparam logic [FW-1:0]    FILT_LAST = FW'(LOSS_FILT - 1);
    localparam logic [RW-1:0]    REL_LAST  = RW'(NUM_RST - 1);
    localparam logic [CNT_W-1:0] LOSS_MAX  = '1;
    localparam seq_state_t       REL_TGT   = (NUM_RST == 1) ? RUN : RELEASE;

    seq_state_t         state, state_nxt;
    logic               lock_s;
    logic [HW-1:0]      hold_cnt;
    logic [SW-1:0]      stg_cnt;
    logic [FW-1:0]      filt_cnt;
    logic [RW-1:0]      rel_cnt;
    logic [CNT_W-1:0]   loss_cnt;
    logic               loss_hit;
    logic               in_rel_run;
    logic [NUM_RST-1:0] rst_vec;

    cdc_sync2 u_lock_sync (
        .clk (i_clk),
        .rst (i_rst),
        .d   (bus.i_locked),
        .q   (lock_s)
    );

    assign in_rel_run = (state == RELEASE) || (state == RUN);
    assign loss_hit   = in_rel_run && !lock_s && (filt_cnt == FILT_LAST);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= WAIT_LOCK;
        else       state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_LOCK: if (lock_s) state_nxt = (HOLD_CYCLES == 1) ? REL_TGT : HOLD;
            HOLD: begin
                if (!lock_s)                    state_nxt = WAIT_LOCK;
                else if (hold_cnt == HOLD_LAST) state_nxt = REL_TGT;
            end
            RELEASE: begin
                if (loss_hit)                                          state_nxt = WAIT_LOCK;
                else if ((stg_cnt == STG_LAST) && (rel_cnt == REL_LAST)) state_nxt = RUN;
            end
            RUN: if (loss_hit) state_nxt = WAIT_LOCK;
            default: state_nxt = WAIT_LOCK;
        endcase
    end

    // Output decode: rel_cnt is the number of channels already released.
    always_comb begin
        rst_vec = '1;
        case (state)
            RELEASE: for (int k = 0; k < NUM_RST; k++) rst_vec[k] = (k >= int'(rel_cnt));
            RUN:     rst_vec = '0;
            default: rst_vec = '1;
        endcase
    end

    // Hold, stagger, loss-filter and loss-event counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_cnt <= '0;
            stg_cnt  <= '0;
            filt_cnt <= '0;
            rel_cnt  <= '0;
            loss_cnt <= '0;
        end else begin
            hold_cnt <= (state == HOLD && lock_s) ? hold_cnt + 1'b1 : '0;
            stg_cnt  <= (state == RELEASE && stg_cnt != STG_LAST) ? stg_cnt + 1'b1 : '0;
            filt_cnt <= (in_rel_run && !lock_s && filt_cnt != FILT_LAST) ? filt_cnt + 1'b1 : '0;
            if (state != RELEASE)        rel_cnt <= RW'(1);
            else if (stg_cnt == STG_LAST) rel_cnt <= rel_cnt + 1'b1;
            if (loss_hit && loss_cnt != LOSS_MAX) loss_cnt <= loss_cnt + 1'b1;
        end
    end

`ifdef PLL_WATCHDOG_EN
    localparam int WW = cnt_w(WD_CYCLES);
    localparam int AW = cnt_w(AR_CYCLES);
    localparam logic [WW-1:0] WD_LAST = WW'(WD_CYCLES - 1);
    localparam logic [AW-1:0] AR_LAST = AW'(AR_CYCLES - 1);

    logic [WW-1:0] wd_cnt;
    logic [AW-1:0] ar_cnt;
    logic          ar_pulse;

    // Watchdog: after WD_CYCLES without lock, pulse PLL reset for AR_CYCLES.
    always_ff @(posedge i_clk) begin
        if (i_rst || lock_s || state != WAIT_LOCK) begin
            wd_cnt   <= '0;
            ar_cnt   <= '0;
            ar_pulse <= 1'b0;
        end else if (ar_pulse) begin
            if (ar_cnt == AR_LAST) begin
                ar_pulse <= 1'b0;
                ar_cnt   <= '0;
            end else begin
                ar_cnt <= ar_cnt + 1'b1;
            end
        end else if (wd_cnt == WD_LAST) begin
            ar_pulse <= 1'b1;
            wd_cnt   <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign bus.o_pll_areset = ar_pulse;
`else
    logic unused_wd;
    assign unused_wd        = WD_CYCLES[0] ^ AR_CYCLES[0];
    assign bus.o_pll_areset = 1'b0;
`endif

    assign bus.o_rst      = rst_vec;
    assign bus.o_ready    = (state == RUN);
    assign bus.o_loss_cnt = loss_cnt;

endmodule

// File: tb/tb_clock_gen_rst_seq.sv
// Scoreboard bench for clock_gen_rst_seq: expected output changes are queued
// with their edge number as lock/reset stimulus is applied.
module tb_clock_gen_rst_seq;
    localparam int NUM_RST = 3;
    localparam int HOLD    = 8;
    localparam int STG     = 4;
    localparam int FILT    = 4;
    localparam int CW      = 2;
    localparam int WD      = 20;
    localparam int AR      = 8;

    typedef struct {
        int                 cyc;
        logic [NUM_RST-1:0] rst;
        logic               rdy;
        logic [CW-1:0]      loss;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_loss;
    int   t_lock;
    int   r0;
    int   xr;
    int   exp_ar;
    logic mon_en = 1'b0;
    logic [NUM_RST+CW:0] prev_obs;
    logic [NUM_RST+CW:0] cur_obs;
    ev_t  mon_e;
    ev_t  exp_q[$];

    clock_gen_rst_seq_if #(.NUM_RST(NUM_RST), .CNT_W(CW)) bus ();

    clock_gen_rst_seq #(
        .NUM_RST(NUM_RST), .HOLD_CYCLES(HOLD), .STAGGER(STG), .LOSS_FILT(FILT),
        .CNT_W(CW), .WD_CYCLES(WD), .AR_CYCLES(AR)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int c, input logic [NUM_RST-1:0] r, input logic rd, input int l);
        ev_t e;
        e.cyc  = c;
        e.rst  = r;
        e.rdy  = rd;
        e.loss = CW'(l);
        exp_q.push_back(e);
    endtask

    // Release schedule for a lock whose first sampling edge is t.
    task automatic push_rel(input int t, input int l);
        push_ev(t + 1 + HOLD,           3'b110, 1'b0, l);
        push_ev(t + 1 + HOLD + STG,     3'b100, 1'b0, l);
        push_ev(t + 1 + HOLD + 2 * STG, 3'b000, 1'b1, l);
    endtask

    // Drop lock for n sampled edges, then raise it; returns the relock edge.
    task automatic drop_relock(input int n, output int t_re);
        int a;
        a = cyc + 1;
        if (n >= FILT) begin
            exp_loss = (exp_loss < 3) ? exp_loss + 1 : 3;
            push_ev(a + 1 + FILT, 3'b111, 1'b0, exp_loss);
        end
        bus.i_locked = 1'b0;
        tick(n);
        bus.i_locked = 1'b1;
        t_re = cyc + 1;
    endtask

    // Compare every output change against the head of the expectation queue.
    always @(negedge clk) begin
        if (mon_en) begin
            cur_obs = {bus.o_rst, bus.o_ready, bus.o_loss_cnt};
            if (cur_obs !== prev_obs) begin
                if (exp_q.size() == 0) begin
                    check_val("spurious_change_edge", cyc, -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("ev_edge", cyc, mon_e.cyc);
                    check_val("ev_rst", bus.o_rst, mon_e.rst);
                    check_val("ev_ready", bus.o_ready, mon_e.rdy);
                    check_val("ev_loss", bus.o_loss_cnt, mon_e.loss);
                end
                prev_obs = cur_obs;
            end
        end
    end

    initial begin
        rst          = 1'b1;
        bus.i_locked = 1'b0;
        exp_loss     = 0;
        tick(3);
        check_val("rst_o_rst", bus.o_rst, 3'b111);
        check_val("rst_ready", bus.o_ready, 0);
        check_val("rst_loss", bus.o_loss_cnt, 0);
        check_val("rst_areset", bus.o_pll_areset, 0);
        rst      = 1'b0;
        prev_obs = {bus.o_rst, bus.o_ready, bus.o_loss_cnt};
        mon_en   = 1'b1;

        // First lock-up sequence.
        tick(5);
        bus.i_locked = 1'b1;
        push_rel(cyc + 1, 0);
        tick(30);

        // Short glitch in RUN: no effect.
        drop_relock(3, t_lock);
        tick(20);

        // Qualified loss and identical relock.
        drop_relock(4, t_lock);
        push_rel(t_lock, exp_loss);
        tick(30);

        // Qualified loss, then a one-cycle drop in HOLD at hold_cnt=5.
        drop_relock(4, t_lock);
        tick(6);
        bus.i_locked = 1'b0;
        tick(1);
        bus.i_locked = 1'b1;
        push_rel(t_lock + 7, exp_loss);
        tick(30);

        // Three more losses: counter saturates at 3.
        for (int i = 0; i < 3; i++) begin
            drop_relock(4, t_lock);
            push_rel(t_lock, exp_loss);
            tick(30);
        end

        // Reset during RELEASE right after o_rst[0] releases.
        drop_relock(4, t_lock);
        r0 = t_lock + 1 + HOLD;
        push_ev(r0, 3'b110, 1'b0, exp_loss);
        tick(r0 + 1 - cyc);
        rst = 1'b1;
        push_ev(r0 + 2, 3'b111, 1'b0, 0);
        tick(1);
        rst      = 1'b0;
        exp_loss = 0;
        push_rel(r0 + 3, 0);
        tick(30);
        check_val("exp_q_empty", exp_q.size(), 0);
        mon_en = 1'b0;

        // PLL reset request with lock held low.
        bus.i_locked = 1'b0;
        rst          = 1'b1;
        tick(2);
        xr  = cyc;
        rst = 1'b0;
        for (int k = 1; k <= 78; k++) begin
            tick(1);
`ifdef PLL_WATCHDOG_EN
            exp_ar = (k >= WD && ((k - WD) % (WD + AR)) < AR) ? 1 : 0;
`else
            exp_ar = 0;
`endif
            check_val("areset_period", bus.o_pll_areset, exp_ar);
        end
        check_val("areset_k", cyc - xr, 78);
        bus.i_locked = 1'b1;
        tick(1);
`ifdef PLL_WATCHDOG_EN
        check_val("areset_lock_k79", bus.o_pll_areset, 1);
        tick(1);
        check_val("areset_lock_k80", bus.o_pll_areset, 1);
`else
        check_val("areset_lock_k79", bus.o_pll_areset, 0);
        tick(1);
        check_val("areset_lock_k80", bus.o_pll_areset, 0);
`endif
        tick(1);
        check_val("areset_lock_k81", bus.o_pll_areset, 0);
        tick(3);
        check_val("areset_lock_k84", bus.o_pll_areset, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
